// File: rtl/dld_enc_pkg.sv
// Shared types and default sizing for the request priority encoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dld_enc_pkg;

  localparam int CW_DEF = 4;
  localparam int N_DEF  = 1 << CW_DEF;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_pick.sv
// Combinational pick: first set bit of pend, searching downward from start with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module prio_pick
  import dld_enc_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int N  = N_DEF
) (
  input  logic [N-1:0]  pend,
  input  logic [CW-1:0] start,
  output logic [CW-1:0] idx,
  output logic          any
);

  logic [CW-1:0] cand;

  // Walk start, start-1, ... wrapping through 0 to N-1; the first set bit wins.
  // N is a power of two, so CW-bit subtraction gives the wrap for free.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = start;
    for (int i = 0; i < N; i++) begin
      cand = start - CW'(i);
      if (!any && pend[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder16x4.sv
// Collects requests into a pending register and presents one encoded index at a time.
// Latency: a request captured at edge k is presented (valid=1) right after edge k.
// Backpressure: code/multi hold until ack; PRIO_ENC_ROUND_ROBIN_EN selects round-robin over fixed priority.
module priority_encoder16x4
  import dld_enc_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int N  = N_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [CW-1:0] code,
  output logic          valid,
  output logic          multi,
  output logic [N-1:0]  pending
);

  state_t        state_q;
  state_t        state_nxt;
  logic [N-1:0]  pend_q;
  logic [N-1:0]  pend_nxt;
  logic [N-1:0]  clr;
  logic [CW-1:0] code_q;
  logic          multi_q;
  logic          multi_nxt;
  logic          load;
  logic [CW-1:0] pick_start;
  logic [CW-1:0] pick_idx;
  logic          pick_any;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [CW-1:0] last_q;

  // Remember the last granted index so the next search starts just below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (load) begin
      last_q <= pick_idx;
    end
  end

  // After reset last_q=0, so the first search starts at N-1.
  assign pick_start = last_q - CW'(1);
`else
  assign pick_start = CW'(N - 1);
`endif

  // Retire the acknowledged bit, then merge new requests; set wins over clear.
  always_comb begin
    clr = '0;
    if (state_q == PRESENT && ack) begin
      clr = N'(1) << code_q;
    end
    pend_nxt = pend_q & ~clr;
    if (en) begin
      pend_nxt = pend_nxt | req;
    end
  end

  assign multi_nxt = ($countones(pend_nxt) > 1);

  prio_pick #(
    .CW (CW),
    .N  (N)
  ) u_pick (
    .pend  (pend_nxt),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: load a new selection when idle with work, or when the current one is acked.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          load      = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          if (pick_any) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending register and the presented code/multi, held stable between loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      code_q  <= '0;
      multi_q <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      if (load) begin
        code_q  <= pick_idx;
        multi_q <= multi_nxt;
      end else if (state_nxt == IDLE) begin
        code_q  <= '0;
        multi_q <= 1'b0;
      end
    end
  end

  // Outputs: everything reads zero outside PRESENT.
  always_comb begin
    valid   = (state_q == PRESENT);
    code    = valid ? code_q : '0;
    multi   = valid ? multi_q : 1'b0;
    pending = pend_q;
  end

endmodule

// File: tb/tb_priority_encoder16x4.sv
module tb_priority_encoder16x4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic        ack   = 1'b0;
  logic [15:0] req   = '0;
  logic [3:0]  code;
  logic        valid;
  logic        multi;
  logic [15:0] pending;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_pend  = '0;
  logic        m_valid = 1'b0;
  logic        m_multi = 1'b0;
  logic [3:0]  m_code  = '0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
  int          m_last  = 0;
`endif

  always #5 clk = ~clk;

  priority_encoder16x4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .multi   (multi),
    .pending (pending)
  );

  function automatic int count_ones(input logic [15:0] p);
    int n = 0;
    for (int i = 0; i < 16; i++) if (p[i]) n++;
    return n;
  endfunction

  // Selection rule: scan downward from a start index with modular wrap.
  function automatic int pick(input logic [15:0] p, input int start);
    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = (start - k + 32) % 16;
      if (p[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model advanced on every clock edge, cleared by async reset.
  initial begin
    logic [15:0] np;
    int w;
    int st;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pend = '0; m_valid = 1'b0; m_multi = 1'b0; m_code = '0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
        m_last = 0;
`endif
      end else begin
        np = m_pend;
        if (m_valid && ack) np[m_code] = 1'b0;
        if (en) np = np | req;
        m_pend = np;
        if (!m_valid || ack) begin
          if (np != 16'h0) begin
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            st = (m_last + 15) % 16;
`else
            st = 15;
`endif
            w = pick(np, st);
            m_code  = w[3:0];
            m_multi = (count_ones(np) > 1);
            m_valid = 1'b1;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            m_last = w;
`endif
          end else begin
            m_valid = 1'b0; m_code = '0; m_multi = 1'b0;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checks++;
        if (valid !== m_valid || code !== m_code || multi !== m_multi || pending !== m_pend) begin
          errors++;
          $display("FAIL model t=%0t got v=%b c=%0d m=%b p=%h expected v=%b c=%0d m=%b p=%h",
                   $time, valid, code, multi, pending, m_valid, m_code, m_multi, m_pend);
        end
      end
    end
  end

  task automatic do_reset();
    #1;
    rst_n = 1'b0; en = 1'b0; req = '0; ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_rr [4];
    logic [31:0] r;

    // reset state, asserted asynchronously before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_pending", int'(pending), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single request, held without ack, then acked
    en = 1'b1; req = 16'h0001; ack = 1'b0;
    @(negedge clk);
    chk("single_valid", int'(valid), 1);
    chk("single_code", int'(code), 0);
    chk("single_multi", int'(multi), 0);
    en = 1'b0; req = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_code", int'(code), 0);
      chk("hold_valid", int'(valid), 1);
    end
    ack = 1'b1;
    @(negedge clk);
    chk("ack_idle", int'(valid), 0);
    ack = 1'b0;

    // two requests in one cycle, ack held
    do_reset();
    en = 1'b1; req = 16'h8001; ack = 1'b1;
    @(negedge clk);
    chk("two_code15", int'(code), 15);
    chk("two_multi", int'(multi), 1);
    en = 1'b0; req = '0;
    @(negedge clk);
    chk("two_code0", int'(code), 0);
    chk("two_valid", int'(valid), 1);
    chk("two_multi0", int'(multi), 0);
    @(negedge clk);
    chk("two_idle", int'(valid), 0);

    // set wins over clear of the same bit
    do_reset();
    en = 1'b1; req = 16'h0008; ack = 1'b0;
    @(negedge clk);
    chk("set_code3", int'(code), 3);
    ack = 1'b1;
    @(negedge clk);
    chk("set_pend3", int'(pending[3]), 1);
    chk("set_again3", int'(code), 3);
    chk("set_valid", int'(valid), 1);
    en = 1'b0; req = '0;
    @(negedge clk);
    chk("set_drain", int'(valid), 0);

    // en=0 ignores requests
    do_reset();
    en = 1'b0; req = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("noen_pending", int'(pending), 0);
      chk("noen_valid", int'(valid), 0);
    end

    // asynchronous reset mid-presentation, then only new requests captured
    do_reset();
    en = 1'b1; req = 16'h00F0; ack = 1'b0;
    @(negedge clk);
    chk("mid_code7", int'(code), 7);
    chk("mid_multi", int'(multi), 1);
    #2 rst_n = 1'b0; en = 1'b0; req = '0;
    #1;
    chk("arst_valid", int'(valid), 0);
    chk("arst_code", int'(code), 0);
    chk("arst_pending", int'(pending), 0);
    chk("arst_multi", int'(multi), 0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; req = 16'h0002;
    @(negedge clk);
    chk("post_code1", int'(code), 1);
    chk("post_pending", int'(pending), 2);
    en = 1'b0; req = '0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    // two requests held with ack always high
    do_reset();
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    exp_rr = '{15, 0, 15, 0};
`else
    exp_rr = '{15, 15, 15, 15};
`endif
    en = 1'b1; req = 16'h8001; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held_code", int'(code), exp_rr[i]);
      chk("held_valid", int'(valid), 1);
    end

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) do_reset();
      en = ($urandom_range(0, 3) != 0);
      r  = $urandom;
      case ($urandom_range(0, 3))
        0: req = r[15:0];
        1: req = r[15:0] & r[31:16];
        2: req = 16'h0;
        default: req = 16'(1) << $urandom_range(0, 15);
      endcase
      ack = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_encoder16x4.md
PRIORITY_ENCODER16X4 -- requirements
Module: priority_encoder16x4

Interface
REQ-001 SHALL have parameter CW, default 4, meaning code width.
REQ-002 SHALL have parameter N, default 16, meaning request count; N SHALL equal 2**CW.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port en, input, 1, capture enable for new requests.
REQ-006 SHALL have port req, input, N, one-hot-or-more request lines (index 0..N-1).
REQ-007 SHALL have port ack, input, 1, consumer accepts the presented code.
REQ-008 SHALL have port code, output, CW, encoded index of the presented request.
REQ-009 SHALL have port valid, output, 1, code is meaningful and held stable.
REQ-010 SHALL have port multi, output, 1, more than one request was pending when code was loaded.
REQ-011 SHALL have port pending, output, N, current pending-request register.

Function
REQ-012 SHALL keep an N-bit pending register: each cycle with en=1, pending <= (pending & ~clr) | req; with en=0, pending <= pending & ~clr.
REQ-013 clr SHALL be the one-hot of code when valid=1 and ack=1, else zero.
REQ-014 Set SHALL win: a req bit high in the same cycle as its own clear leaves that bit pending.
REQ-015 SHALL implement FSM IDLE/PRESENT; reset state is IDLE.
REQ-016 IDLE: if next-pending (the updated pending value) is nonzero, load code with the selected index and multi with popcount>1, then go to PRESENT; otherwise stay in IDLE.
REQ-017 Latency: a req bit first seen at edge k (IDLE, en=1) SHALL give valid=1 with the matching code after edge k.
REQ-018 PRESENT: valid=1; code and multi SHALL stay stable until ack=1.
REQ-019 PRESENT with ack=1: if the next-pending value with the acked bit removed is nonzero, SHALL load the next selection in the same edge (valid stays 1); otherwise SHALL go to IDLE (valid=0).
REQ-020 ack while valid=0 SHALL be ignored.
REQ-021 en=0 SHALL NOT abort presentation; pending bits SHALL be retained.
REQ-022 Default selection SHALL be fixed priority: the highest set index wins (index 15 over 0).
REQ-023 In IDLE, valid=0 and code=0.

Reset
REQ-024 rst_n=0 SHALL immediately force pending=0, code=0, valid=0, multi=0, state=IDLE, and the round-robin pointer=0 where present.
REQ-025 Reset mid-presentation SHALL discard all pending requests; after release, only new req is captured.

Configuration
REQ-026 Macro PRIO_ENC_ROUND_ROBIN_EN defined: selection SHALL search downward from (last granted index - 1), wrapping 0->N-1; the pointer updates on each load; after reset the search starts at N-1.
REQ-027 Macro undefined: fixed priority per REQ-022; no pointer register SHALL exist.

Structure
REQ-028 Package dld_enc_pkg SHALL hold the state enum typedef (IDLE, PRESENT) and the CW/N default constants.
REQ-029 The combinational pick (pending plus start pointer -> index, any) SHALL be a sub-module named prio_pick, instantiated once.

Verification
REQ-030 Reset then req=16'h0001, en=1 for 1 cycle -> next cycle valid=1, code=0, multi=0; hold ack=0 for 5 cycles -> code stable; ack=1 -> valid=0.
REQ-031 req=16'h8001 for 1 cycle, ack held 1 -> code=15 with multi=1, then code=0 on the next cycle with valid held, then valid=0.
REQ-032 PRESENT code=3 with ack=1 and req[3]=1 in the same cycle -> pending[3] stays 1; code=3 is presented again.
REQ-033 en=0, req=16'hFFFF -> pending stays 0 and valid stays 0.
REQ-034 Assert rst_n=0 asynchronously mid-PRESENT -> valid, code, pending go to 0 before the next clock edge.
REQ-035 With PRIO_ENC_ROUND_ROBIN_EN, req=16'h8001 held, ack always 1 -> codes alternate 15, 0, 15, 0.
